// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_defs -- shared bus definitions
//
// Purpose : constants and small helpers shared by the bus arbiter and the bus
//           controllers. Requester IDs, the "no grant" code and the arbiter
//           state encodings live here so every unit agrees on them.
//
// Contents: NREQ, TIMEOUT_CYCLES_DEF, requester IDs ID0..ID2, NO_GRANT,
//           arbiter states ST_IDLE/ST_GRANT/ST_TURN, id_t, req_vec_t and
//           onehot_to_id().
// -----------------------------------------------------------------------------
package bus_defs;

   // Number of bus requesters; fixed at 3 in this revision.
   localparam int NREQ = 3;

   // Default maximum tenure, used only when the timeout feature is built in.
   localparam int TIMEOUT_CYCLES_DEF = 64;

   typedef logic [1:0]      id_t;
   typedef logic [NREQ-1:0] req_vec_t;

   // Requester IDs as seen on GNT_ID and by the bus controllers.
   localparam id_t ID0      = 2'd0;
   localparam id_t ID1      = 2'd1;
   localparam id_t ID2      = 2'd2;
   localparam id_t NO_GRANT = 2'b11;

   // Arbiter state encodings (kept as plain constants for older tooling).
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_TURN  = 2'd2;

   // Encode a one-hot (or zero) requester vector into an ID; zero maps to
   // NO_GRANT so the result can drive GNT_ID directly.
   function automatic id_t onehot_to_id(input req_vec_t vec);
      id_t id;
      id = NO_GRANT;
      unique case (vec)
         3'b001:  id = ID0;
         3'b010:  id = ID1;
         3'b100:  id = ID2;
         default: id = NO_GRANT;
      endcase
      return id;
   endfunction

endpackage : bus_defs

// File: rtl/bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick -- round-robin winner selection (combinational)
//
// Purpose : given the current request vector and the ID that won most
//           recently, choose the next winner. Priority starts at the ID just
//           after `last` and wraps around, so the previous winner is always
//           considered last.
//
// Ports   : br    in  [2:0] request vector, one bit per requester ID
//           last  in  [1:0] ID of the most recent winner
//           pick  out [2:0] one-hot winner, all-zero when nothing requests
//           valid out       at least one request is present
// -----------------------------------------------------------------------------
module rr_pick
   import bus_defs::*;
(
   input  logic [NREQ-1:0] br,
   input  logic [1:0]      last,
   output logic [NREQ-1:0] pick,
   output logic            valid
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // branch, so no path can leave it unassigned and infer a latch.
      pick = '0;
      unique case (last)
         ID0: begin
            // order 1, 2, 0
            if      (br[1]) pick = 3'b010;
            else if (br[2]) pick = 3'b100;
            else if (br[0]) pick = 3'b001;
         end
         ID1: begin
            // order 2, 0, 1
            if      (br[2]) pick = 3'b100;
            else if (br[0]) pick = 3'b001;
            else if (br[1]) pick = 3'b010;
         end
         default: begin
            // last == 2 (and the unused code 3): order 0, 1, 2
            if      (br[0]) pick = 3'b001;
            else if (br[1]) pick = 3'b010;
            else if (br[2]) pick = 3'b100;
         end
      endcase
   end

   assign valid = |br;

endmodule : rr_pick

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter -- three-requester round-robin bus arbiter
//
// Purpose : grants the shared bus to one of three requesters. A grant lasts
//           as long as the winner holds its request; every release is
//           followed by exactly one turnaround cycle with no grant before the
//           next winner is chosen. Priority rotates so the previous winner is
//           served last. There is no preemption other than the optional
//           tenure timeout.
//
// Build option:
//   ARB_TIMEOUT_EN  when defined, a tenure counter revokes a grant that has
//                   lasted TIMEOUT_CYCLES cycles and pulses TIMEOUT. When
//                   undefined, tenure is unbounded and TIMEOUT is tied low.
//
// Parameters:
//   NREQ            number of requesters (must be 3)
//   TIMEOUT_CYCLES  maximum tenure in cycles, 2..255 (timeout build only)
//
// Ports   : BUS_CLK   in       bus clock, rising edge
//           RST       in       synchronous reset, active low
//           BR        in  [2:0] bus requests, level-held for the tenure
//           BG        out [2:0] registered grant, one-hot or zero
//           GNT_ID    out [1:0] ID of current grantee, 2'b11 when none
//           BUS_IDLE  out       high whenever no grant is active
//           TIMEOUT   out       one-cycle pulse when a tenure is revoked
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int NREQ           = bus_defs::NREQ,
   parameter int TIMEOUT_CYCLES = bus_defs::TIMEOUT_CYCLES_DEF
) (
   input  logic            BUS_CLK,
   input  logic            RST,
   input  logic [NREQ-1:0] BR,
   output logic [NREQ-1:0] BG,
   output logic [1:0]      GNT_ID,
   output logic            BUS_IDLE,
   output logic            TIMEOUT
);

   import bus_defs::*;

   // Reject unsupported configurations at elaboration time.
   if (NREQ != 3 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
      $error("bus_arbiter: NREQ must be 3 and TIMEOUT_CYCLES must be 2..255");
   end

   logic [1:0]      state;
   logic [1:0]      last;
   logic [NREQ-1:0] pick;
   logic            pick_valid;
   id_t             pick_id;
   logic            owner_req;
   logic            tenure_expired;

   // -------------------------------------------------------------------------
   // Winner selection
   // -------------------------------------------------------------------------
   rr_pick u_rr_pick (
      .br    (BR),
      .last  (last),
      .pick  (pick),
      .valid (pick_valid)
   );

   assign pick_id = onehot_to_id(pick);

   // BG is one-hot while granting, so masking BR with it yields the current
   // owner's request without indexing by GNT_ID.
   assign owner_req = |(BR & BG);

   // -------------------------------------------------------------------------
   // Optional tenure timeout
   // -------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] TENURE_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tenure_cnt;
   logic       timeout_q;

   assign tenure_expired = (tenure_cnt == TENURE_LAST);

   // The counter is held at zero outside GRANT, so it is already clear on the
   // cycle a tenure starts and counts completed grant cycles from there.
   always_ff @(posedge BUS_CLK) begin
      if (!RST) begin
         tenure_cnt <= '0;
         timeout_q  <= 1'b0;
      end else begin
         // Pulse only when the owner still wants the bus; a voluntary release
         // on the same edge is an ordinary release.
         timeout_q <= (state == ST_GRANT) && owner_req && tenure_expired;
         if (state == ST_GRANT) begin
            tenure_cnt <= tenure_cnt + 8'd1;
         end else begin
            tenure_cnt <= '0;
         end
      end
   end

   assign TIMEOUT = timeout_q;
`else
   assign tenure_expired = 1'b0;
   assign TIMEOUT        = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Arbitration FSM and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge BUS_CLK) begin
      // NOTE: all state and output registers use non-blocking assignments so
      // every register samples pre-edge values, independent of statement order.
      if (!RST) begin
         // A live grant is dropped here directly; reset never passes through
         // the turnaround state.
         state    <= ST_IDLE;
         last     <= ID2;          // ID 0 wins the first arbitration
         BG       <= '0;
         GNT_ID   <= NO_GRANT;
         BUS_IDLE <= 1'b1;
      end else begin
         unique case (state)
            ST_GRANT: begin
               // Release or revoke: drop the grant on this edge and spend one
               // cycle in turnaround. `last` already holds the owner, so it
               // is served last at the next selection.
               if (!owner_req || tenure_expired) begin
                  state    <= ST_TURN;
                  BG       <= '0;
                  GNT_ID   <= NO_GRANT;
                  BUS_IDLE <= 1'b1;
               end
            end

            default: begin
               // IDLE and TURN both select on the edge that ends them. TURN
               // lasts exactly one cycle because it is only ever entered
               // from GRANT and always left on the next edge.
               if (pick_valid) begin
                  state    <= ST_GRANT;
                  BG       <= pick;
                  GNT_ID   <= pick_id;
                  last     <= pick_id;
                  BUS_IDLE <= 1'b0;
               end else begin
                  state    <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter -- self-checking bench for bus_arbiter
//
// A behavioural model tracks only "who owns the bus" and the round-robin
// pointer; a compare process checks all outputs against it every cycle.
// Directed scenarios add hand-computed literal expectations on top.
// Built with TIMEOUT_CYCLES = 8; the timeout scenario follows ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

   localparam int TO_CYC = 8;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [2:0] br;
   logic [2:0] bg;
   logic [1:0] gnt_id;
   logic       bus_idle;
   logic       timeout;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   bus_arbiter #(
      .NREQ           (3),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .BUS_CLK  (clk),
      .RST      (rst),
      .BR       (br),
      .BG       (bg),
      .GNT_ID   (gnt_id),
      .BUS_IDLE (bus_idle),
      .TIMEOUT  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic int oh2id(input logic [2:0] v);
      if (v[0]) return 0;
      if (v[1]) return 1;
      if (v[2]) return 2;
      return -1;
   endfunction

   // ---------------------------------------------------------------------------
   // Behavioural model: owner (-1 = nobody), last winner, tenure length.
   // A release never re-grants on the same edge, which yields the turnaround.
   // ---------------------------------------------------------------------------
   int m_owner = -1;
   int m_last  = 2;
   int m_ten   = 0;
   bit m_to    = 1'b0;

   initial begin
      int cand;
      forever begin
         @(posedge clk);
         if (!rst) begin
            m_owner = -1;
            m_last  = 2;
            m_ten   = 0;
            m_to    = 1'b0;
         end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
               if (!br[m_owner]) begin
                  m_owner = -1;
               end else if (TO_EN && m_ten == TO_CYC - 1) begin
                  m_owner = -1;
                  m_to    = 1'b1;
               end else begin
                  m_ten++;
               end
            end else if (br != 3'b000) begin
               for (int k = 1; k <= 3; k++) begin
                  cand = (m_last + k) % 3;
                  if (m_owner < 0 && br[cand]) m_owner = cand;
               end
               m_last = m_owner;
               m_ten  = 0;
            end
         end
      end
   end

   // Compare process: outputs are sampled on the falling edge.
   initial begin
      logic [2:0] exp_bg;
      logic [1:0] exp_id;
      forever begin
         @(negedge clk);
         if (check_en) begin
            exp_bg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
            exp_id = (m_owner < 0) ? 2'b11  : 2'(m_owner);
            check("model_bg",       32'(bg),       32'(exp_bg));
            check("model_gnt_id",   32'(gnt_id),   32'(exp_id));
            check("model_bus_idle", 32'(bus_idle), 32'(m_owner < 0));
            check("model_timeout",  32'(timeout),  32'(m_to));
            check("bg_onehot",      32'($countones(bg) <= 1), 32'd1);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Directed scenarios
   // ---------------------------------------------------------------------------
   initial begin
      int order[$];
      int gaps[$];
      int exp_order[4];
      int ten;
      int gap;
      bit prev_zero;
      bit seen;
      logic [2:0] cur;

      exp_order = '{0, 1, 2, 0};
      rst = 1'b0;
      br  = 3'b111;

      // Reset held two cycles with all requests up.
      step();
      check_en = 1'b1;
      step();
      check("rst_bg",       32'(bg),       32'h0);
      check("rst_gnt_id",   32'(gnt_id),   32'h3);
      check("rst_bus_idle", 32'(bus_idle), 32'h1);
      rst = 1'b1;
      step();
      check("rst_first_grant", 32'(bg), 32'h1);

      // Rotation: BR=111, each grantee drops its request after 4 cycles.
      ten = 0; gap = 0; prev_zero = 1'b1; seen = 1'b0;
      for (int i = 0; i < 18; i++) begin
         cur = bg;
         if (cur != 3'b000) begin
            if (prev_zero) begin
               order.push_back(oh2id(cur));
               if (seen) gaps.push_back(gap);
               seen = 1'b1;
               gap  = 0;
            end
            prev_zero = 1'b0;
            ten++;
            if (ten == 4) begin
               br  = 3'b111 & ~cur;
               ten = 0;
            end
         end else begin
            prev_zero = 1'b1;
            gap++;
            br = 3'b111;
         end
         step();
      end
      check("rot_count", 32'(order.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         check("rot_order", 32'((i < order.size()) ? order[i] : -1), 32'(exp_order[i]));
      for (int i = 0; i < 3; i++)
         check("rot_gap", 32'((i < gaps.size()) ? gaps[i] : -1), 32'd1);
      br = 3'b000;
      step(); step(); step();

      // Single requester pulsed for three cycles, then re-requested.
      br = 3'b010;
      step(); check("single_bg1", 32'(bg), 32'h2);
      step(); check("single_bg2", 32'(bg), 32'h2);
      step(); check("single_bg3", 32'(bg), 32'h2);
      br = 3'b000;
      step(); check("single_turn_bg",   32'(bg),       32'h0);
              check("single_turn_idle", 32'(bus_idle), 32'h1);
      step(); check("single_idle_bg",   32'(bg),       32'h0);
              check("single_idle_idle", 32'(bus_idle), 32'h1);
      br = 3'b010;
      step(); check("single_regrant_bg", 32'(bg),     32'h2);
              check("single_regrant_id", 32'(gnt_id), 32'h1);
      br = 3'b000;
      step(); step();

      // Late request from ID 2 while ID 0 owns the bus.
      br = 3'b001;
      step(); check("late_bg0", 32'(bg), 32'h1);
      br = 3'b101;
      step(); check("late_hold1", 32'(bg), 32'h1);
      step(); check("late_hold2", 32'(bg), 32'h1);
      br = 3'b100;
      step(); check("late_turn", 32'(bg), 32'h0);
      step(); check("late_bg2",  32'(bg),     32'h4);
              check("late_id2",  32'(gnt_id), 32'h2);
      br = 3'b000;
      step(); step();

`ifdef ARB_TIMEOUT_EN
      // Timeout: ID 0 holds past the limit while ID 1 waits.
      br = 3'b011;
      for (int i = 0; i < TO_CYC; i++) begin
         step();
         check("to_hold_bg", 32'(bg),      32'h1);
         check("to_hold_to", 32'(timeout), 32'h0);
      end
      step(); check("to_revoke_bg", 32'(bg),      32'h0);
              check("to_pulse",     32'(timeout), 32'h1);
      step(); check("to_next_bg",   32'(bg),      32'h2);
              check("to_pulse_end", 32'(timeout), 32'h0);
`else
      // Without the timeout build a long tenure is never revoked.
      br = 3'b011;
      for (int i = 0; i < 12; i++) begin
         step();
         check("notimeout_bg", 32'(bg),      32'h1);
         check("notimeout_to", 32'(timeout), 32'h0);
      end
`endif
      br = 3'b000;
      step(); step();

      // Mid-tenure reset: grant dropped on the reset edge, then ID 1 first.
      br = 3'b110;
      step(); check("mid_busy", 32'(bus_idle), 32'h0);
      rst = 1'b0;
      step(); check("mid_rst_bg",   32'(bg),       32'h0);
              check("mid_rst_id",   32'(gnt_id),   32'h3);
              check("mid_rst_idle", 32'(bus_idle), 32'h1);
      rst = 1'b1;
      step(); check("mid_post_bg", 32'(bg), 32'h2);
      br = 3'b000;
      step(); step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_bus_arbiter
